mem_access_ctrl: RTL and testbench

Sequences data-memory accesses for the instruction held in the EX/MEM pipeline register. It launches one request per load or store on a req/ack memory port and stalls the pipeline until the access completes. For loads, it extracts the addressed byte or halfword and sign- or zero-extends it for writeback. It sits between the EX/MEM register outputs and the data memory, and drives the pipeline `enable`/stall network.

---
 rtl/mem_access_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Sequences one data-memory access per load/store held in the
//            EX/MEM register over a req/ack port. Stalls the pipeline while
//            the access is outstanding and produces the sign/zero-extended
//            load result for writeback.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1  clock, rising edge
//   rst          in   1  asynchronous active-high reset
//   em_valid     in   1  EX/MEM instruction is live
//   em_op        in   7  opcode (load 0000011, store 0100011)
//   em_funct3    in   3  access size / signedness
//   em_daddr     in  32  byte address
//   em_we        in   4  store byte enables (lane aligned)
//   em_dwdata    in  32  store data (lane aligned)
//   mem_req      out  1  memory request, held until ack
//   mem_addr     out 32  latched word address
//   mem_we       out  4  latched byte enables (0 for loads)
//   mem_wdata    out 32  latched store data
//   mem_ack      in   1  memory completion (only observed in WAIT)
//   mem_rdata    in  32  read word, valid with mem_ack
//   stall        out  1  freezes PC, IF/ID, ID/EX, EX/MEM
//   ld_data      out 32  extended load result
//   ld_valid     out  1  one-cycle pulse, ld_data valid
//   misalign     out  1  one-cycle pulse, misaligned access dropped
//   timeout_err  out  1  sticky timeout flag, cleared by rst only
// ============================================================================
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        em_valid,
  input  logic [6:0]  em_op,
  input  logic [2:0]  em_funct3,
  input  logic [31:0] em_daddr,
  input  logic [3:0]  em_we,
  input  logic [31:0] em_dwdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        misalign,
  output logic        timeout_err
);

  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;
  localparam logic [7:0] C_TIMEOUT  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_addr;
  logic [3:0]  r_we;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_is_load;
  logic [7:0]  r_cnt;
  logic [31:0] r_ld_data;
  logic        r_ld_valid;
  logic        r_misalign;
  logic        r_timeout_err;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_acc;
  logic        w_ld_mis;
  logic        w_st_mis;
  logic        w_misal;
  logic [7:0]  w_cnt_inc;
  logic        w_stall;
  logic        w_launch;
  logic        w_misal_hit;
  logic        w_ack_hit;
  logic        w_tmo_hit;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // --------------------------------------------------------------------------
  // Access qualification and alignment
  // --------------------------------------------------------------------------
  assign w_is_load  = (em_op == C_OP_LOAD);
  assign w_is_store = (em_op == C_OP_STORE) && (em_we != 4'b0000);
  assign w_acc      = em_valid && (w_is_load || w_is_store);

  assign w_ld_mis = (((em_funct3 == 3'b001) || (em_funct3 == 3'b101)) && em_daddr[0]) ||
                    ((em_funct3 == 3'b010) && (em_daddr[1:0] != 2'b00));
  // Stores arrive with lane-aligned enables; only a full-word store can
  // straddle a word boundary.
  assign w_st_mis = (em_we == 4'b1111) && (em_daddr[1:0] != 2'b00);
  assign w_misal  = w_is_load ? w_ld_mis : w_st_mis;

  assign w_cnt_inc = r_cnt + 8'd1;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_launch     = 1'b0;
    w_misal_hit  = 1'b0;
    w_ack_hit    = 1'b0;
    w_tmo_hit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_stall = 1'b1;
          w_state_next = S_RESP;
          if (w_misal) begin
            w_misal_hit = 1'b1;
          end else begin
            w_launch     = 1'b1;
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        // Ack takes priority over an expiring counter in the same cycle.
        if (mem_ack) begin
          w_ack_hit    = 1'b1;
          w_state_next = S_RESP;
        end else if (w_cnt_inc == C_TIMEOUT) begin
          w_tmo_hit    = 1'b1;
          w_state_next = S_RESP;
        end
      end
      // RESP lets the pipeline advance so the same instruction is not relaunched.
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load extraction from the returned word
  // --------------------------------------------------------------------------
  assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_ext = mem_rdata;
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr        <= 32'd0;
      r_we          <= 4'd0;
      r_wdata       <= 32'd0;
      r_f3          <= 3'd0;
      r_off         <= 2'd0;
      r_is_load     <= 1'b0;
      r_cnt         <= 8'd0;
      r_ld_data     <= 32'd0;
      r_ld_valid    <= 1'b0;
      r_misalign    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ld_valid <= w_ack_hit && r_is_load;
      r_misalign <= w_misal_hit;

      if (w_launch) begin
        r_addr    <= {em_daddr[31:2], 2'b00};
        r_we      <= w_is_load ? 4'b0000 : em_we;
        r_wdata   <= em_dwdata;
        r_f3      <= em_funct3;
        r_off     <= em_daddr[1:0];
        r_is_load <= w_is_load;
        r_cnt     <= 8'd0;
      end else if ((r_state == S_WAIT) && !w_ack_hit && !w_tmo_hit) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_ack_hit && r_is_load) begin
        r_ld_data <= w_ext;
      end else if (w_misal_hit || w_tmo_hit) begin
        r_ld_data <= 32'd0;
      end

      if (w_tmo_hit) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_req     = (r_state == S_WAIT);
  assign mem_addr    = r_addr;
  assign mem_we      = r_we;
  assign mem_wdata   = r_wdata;
  assign stall       = w_stall;
  assign ld_data     = r_ld_data;
  assign ld_valid    = r_ld_valid;
  assign misalign    = r_misalign;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed self-checking bench for mem_access_ctrl (TIMEOUT = 4).
//            Expected load results are queued when an access is driven and
//            compared when ld_valid is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        em_valid;
  logic [6:0]  em_op;
  logic [2:0]  em_funct3;
  logic [31:0] em_daddr;
  logic [3:0]  em_we;
  logic [31:0] em_dwdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        misalign;
  logic        timeout_err;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] sb_q[$];

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .em_valid    (em_valid),
    .em_op       (em_op),
    .em_funct3   (em_funct3),
    .em_daddr    (em_daddr),
    .em_we       (em_we),
    .em_dwdata   (em_dwdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .ld_data     (ld_data),
    .ld_valid    (ld_valid),
    .misalign    (misalign),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one access in cycle 0, acks in cycle k (k = 0: never) and
  // observes the DUT once per cycle until the stall releases.
  task automatic run_access(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [3:0] we,
                            input logic [31:0] wdata, input int k, input logic [31:0] rdata,
                            input int e_req, input int e_stall, input int e_ldv, input int e_mis,
                            input logic [31:0] e_addr, input logic [3:0] e_we,
                            input logic [31:0] e_ld);
    int          req_n   = 0;
    int          stall_n = 0;
    int          ldv_n   = 0;
    int          mis_n   = 0;
    int          c       = 0;
    bit          done    = 1'b0;
    logic [31:0] a_seen  = 32'd0;
    logic [3:0]  we_seen = 4'd0;
    logic [31:0] wd_seen = 32'd0;
    if (e_ldv == 1) sb_q.push_back(e_ld);
    @(posedge clk); #1;
    em_valid = 1'b1; em_op = op; em_funct3 = f3; em_daddr = addr;
    em_we = we; em_dwdata = wdata; mem_ack = 1'b0;
    #1;
    if (stall) stall_n++;
    if (mem_req) req_n++;
    while (!done && c < 20) begin
      @(posedge clk); #1;
      c++;
      mem_ack   = (c == k);
      mem_rdata = rdata;
      #1;
      if (stall) stall_n++;
      if (mem_req) begin
        if (req_n == 0) begin
          a_seen = mem_addr; we_seen = mem_we; wd_seen = mem_wdata;
        end
        req_n++;
      end
      if (misalign) mis_n++;
      if (ld_valid) begin
        ldv_n++;
        if (sb_q.size() == 0) chk({tag, "_ldv_unexpected"}, 32'd1, 32'd0);
        else chk({tag, "_ld_data"}, ld_data, sb_q.pop_front());
      end
      if (!stall) done = 1'b1;
    end
    chk({tag, "_done_in_bound"}, 32'(done), 32'd1);
    mem_ack  = 1'b0;
    em_valid = 1'b0;
    chk({tag, "_req_cycles"},   32'(req_n),   32'(e_req));
    chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(e_stall));
    chk({tag, "_ldv_pulses"},   32'(ldv_n),   32'(e_ldv));
    chk({tag, "_misalign"},     32'(mis_n),   32'(e_mis));
    if (e_req > 0) begin
      chk({tag, "_mem_addr"},  a_seen,         e_addr);
      chk({tag, "_mem_we"},    32'(we_seen),   32'(e_we));
      chk({tag, "_mem_wdata"}, wd_seen,        wdata);
    end
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    rst = 1'b1; em_valid = 1'b0; em_op = 7'd0; em_funct3 = 3'd0; em_daddr = 32'd0;
    em_we = 4'd0; em_dwdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req",  32'(mem_req),  32'd0);
    chk("rst_stall",    32'(stall),    32'd0);
    chk("rst_ld_valid", 32'(ld_valid), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_tmo_err",  32'(timeout_err), 32'd0);
    chk("rst_ld_data",  ld_data,       32'd0);
    chk("rst_mem_addr", mem_addr,      32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    rst = 1'b0;

    //          tag    op  f3      addr         we      wdata         k  rdata          req stl ldv mis e_addr       e_we     e_ld
    run_access("lw",   LD, 3'b010, 32'h100, 4'b0000, 32'h0,        3, 32'hDEADBEEF, 3, 4, 1, 0, 32'h100, 4'b0000, 32'hDEADBEEF);
    run_access("lb",   LD, 3'b000, 32'h103, 4'b0000, 32'h0,        1, 32'h80FF1234, 1, 2, 1, 0, 32'h100, 4'b0000, 32'hFFFFFF80);
    run_access("lbu",  LD, 3'b100, 32'h103, 4'b0000, 32'h0,        1, 32'h80FF1234, 1, 2, 1, 0, 32'h100, 4'b0000, 32'h00000080);
    run_access("lh",   LD, 3'b001, 32'h102, 4'b0000, 32'h0,        2, 32'h80017FFF, 2, 3, 1, 0, 32'h100, 4'b0000, 32'hFFFF8001);
    run_access("lhu",  LD, 3'b101, 32'h102, 4'b0000, 32'h0,        2, 32'h80017FFF, 2, 3, 1, 0, 32'h100, 4'b0000, 32'h00008001);
    run_access("lb1",  LD, 3'b000, 32'h101, 4'b0000, 32'h0,        1, 32'h0000A500, 1, 2, 1, 0, 32'h100, 4'b0000, 32'hFFFFFFA5);
    run_access("sb",   ST, 3'b000, 32'h206, 4'b0100, 32'h00AB0000, 1, 32'h0,        1, 2, 0, 0, 32'h204, 4'b0100, 32'h0);
    chk("sb_ld_data_held", ld_data, 32'hFFFFFFA5);
    // Ack arriving in the same cycle the counter expires: ack wins.
    run_access("acktmo", LD, 3'b010, 32'h300, 4'b0000, 32'h0,      4, 32'h12345678, 4, 5, 1, 0, 32'h300, 4'b0000, 32'h12345678);
    chk("acktmo_no_err", 32'(timeout_err), 32'd0);
    run_access("mis_lw", LD, 3'b010, 32'h101, 4'b0000, 32'h0,      0, 32'h0,        0, 1, 0, 1, 32'h0,   4'b0000, 32'h0);
    chk("mis_lw_ld_zero", ld_data, 32'd0);
    run_access("mis_lh", LD, 3'b001, 32'h103, 4'b0000, 32'h0,      0, 32'h0,        0, 1, 0, 1, 32'h0,   4'b0000, 32'h0);
    run_access("mis_sw", ST, 3'b010, 32'h202, 4'b1111, 32'h55AA55AA, 0, 32'h0,      0, 1, 0, 1, 32'h0,   4'b0000, 32'h0);
    run_access("st_we0", ST, 3'b000, 32'h208, 4'b0000, 32'h0,      0, 32'h0,        0, 0, 0, 0, 32'h0,   4'b0000, 32'h0);
    run_access("lw011",  LD, 3'b011, 32'h106, 4'b0000, 32'h0,      1, 32'h13572468, 1, 2, 1, 0, 32'h104, 4'b0000, 32'h13572468);
    run_access("tmo",    LD, 3'b010, 32'h500, 4'b0000, 32'h0,      0, 32'hCAFEF00D, 4, 5, 0, 0, 32'h500, 4'b0000, 32'h0);
    chk("tmo_err_set",  32'(timeout_err), 32'd1);
    chk("tmo_ld_zero",  ld_data, 32'd0);
    run_access("post_tmo", LD, 3'b100, 32'h602, 4'b0000, 32'h0,    1, 32'h00C30000, 1, 2, 1, 0, 32'h600, 4'b0000, 32'h000000C3);
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset while a second access is in WAIT.
    @(posedge clk); #1;
    em_valid = 1'b1; em_op = LD; em_funct3 = 3'b010; em_daddr = 32'h400; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstwait_req_before", 32'(mem_req), 32'd1);
    #1;
    rst = 1'b1; em_valid = 1'b0;
    #1;
    chk("rstwait_req",     32'(mem_req),     32'd0);
    chk("rstwait_stall",   32'(stall),       32'd0);
    chk("rstwait_tmo_err", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_access("recover", LD, 3'b010, 32'h700, 4'b0000, 32'h0, 1, 32'h0BADF00D, 1, 2, 1, 0, 32'h700, 4'b0000, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
